boid_flock_engine: RTL and testbench

- Parametrised successor to the single-boid accelerator: holds NUM_BOIDS boids in on-chip registers.
- Each frame it runs the full O(N²) boids update in fix15, matching the team C model bit-exactly: separation, alignment, cohesion, edge turn, speed clamp via alpha-max-beta-min, then position integrate.
- Sits between the HPS load path and the VGA/M10k draw logic, which reads positions back after `done`.

---
 rtl/boid_pkg.sv | 45 ++++
 rtl/boid_fix15_div.sv | 69 ++++++
 rtl/boid_flock_engine.sv | 222 ++++++++++++++++++++++
 tb/tb_boid_flock_engine.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/boid_pkg.sv
// Shared fix15 types, arithmetic helpers, default tuning constants and FSM states
// for the boid flock engine.
package boid_pkg;

  typedef logic signed [31:0] fix15_t;

  localparam fix15_t DEF_VISUAL_SQ  = 32'sh0320_0000;
  localparam fix15_t DEF_PROTECT_SQ = 32'sh0020_0000;
  localparam fix15_t DEF_VISUAL     = 32'sh0014_0000;
  localparam fix15_t DEF_CENTERING  = 32'sh0000_0010;
  localparam fix15_t DEF_AVOID      = 32'sh0000_0666;
  localparam fix15_t DEF_MATCHING   = 32'sh0000_0666;
  localparam fix15_t DEF_TURN       = 32'sh0000_1999;
  localparam fix15_t DEF_MAXSPEED   = 32'sh0003_0000;
  localparam fix15_t DEF_MINSPEED   = 32'sh0001_8000;
  localparam fix15_t DEF_LEFT       = 32'sh0032_0000;
  localparam fix15_t DEF_RIGHT      = 32'sh010E_0000;
  localparam fix15_t DEF_TOP        = 32'sh0032_0000;
  localparam fix15_t DEF_BOTTOM     = 32'sh00BE_0000;

  localparam int DIV_LAT = 48;

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_SCAN, S_DIV, S_APPLY, S_EDGE,
    S_SPEED, S_SDIV, S_POS, S_NEXT, S_DONE
  } state_e;

  // Full 64-bit product, arithmetic shift, then truncate to 32 bits.
  function automatic fix15_t fmul(input fix15_t a, input fix15_t b);
    return fix15_t'((64'(a) * 64'(b)) >>> 15);
  endfunction

  function automatic fix15_t fabs(input fix15_t a);
    return a[31] ? -a : a;
  endfunction

  function automatic fix15_t amax_bmin(input fix15_t a, input fix15_t b);
    fix15_t aa;
    fix15_t bb;
    aa = fabs(a);
    bb = fabs(b);
    return (aa > bb) ? aa + (bb >>> 1) : bb + (aa >>> 1);
  endfunction

endpackage

// File: rtl/boid_fix15_div.sv
// Sequential signed restoring divider computing (a<<15)/b, truncated toward zero.
// One quotient bit per cycle; valid_o pulses exactly DIV_LAT cycles after start_i.
module boid_fix15_div
  import boid_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   start_i,
  input  fix15_t dividend_i,
  input  fix15_t divisor_i,
  output logic   valid_o,
  output fix15_t quot_o
);

  logic [47:0] dvd_q;
  logic [31:0] rem_q;
  logic [31:0] dsr_q;
  logic [5:0]  cnt_q;
  logic        run_q;
  logic        neg_q;
  logic        valid_q;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] rem_sh;
  logic [31:0] rem_diff;
  logic        ge;

  assign abs_a    = dividend_i[31] ? 32'(-dividend_i) : 32'(dividend_i);
  assign abs_b    = divisor_i[31]  ? 32'(-divisor_i)  : 32'(divisor_i);
  assign rem_sh   = {rem_q, dvd_q[47]};
  assign ge       = rem_sh >= {1'b0, dsr_q};
  // Remainder stays below the divisor, so the low 32 bits of the difference are exact.
  assign rem_diff = rem_sh[31:0] - dsr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dvd_q   <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      neg_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (start_i) begin
        dvd_q <= {1'b0, abs_a, 15'd0};
        rem_q <= '0;
        dsr_q <= abs_b;
        neg_q <= dividend_i[31] ^ divisor_i[31];
        cnt_q <= 6'(DIV_LAT);
        run_q <= 1'b1;
      end else if (run_q) begin
        dvd_q <= {dvd_q[46:0], ge};
        rem_q <= ge ? rem_diff : rem_sh[31:0];
        cnt_q <= cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          run_q   <= 1'b0;
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign valid_o = valid_q;
  assign quot_o  = neg_q ? -$signed(dvd_q[31:0]) : $signed(dvd_q[31:0]);

endmodule

// File: rtl/boid_flock_engine.sv
// NUM_BOIDS-boid flocking engine: per frame, runs the O(N^2) boids update in fix15,
// updating each boid in place so later boids see earlier results.
module boid_flock_engine
  import boid_pkg::*;
#(
  parameter int     NUM_BOIDS  = 8,
  parameter int     IDX_W      = $clog2(NUM_BOIDS),
  parameter fix15_t VISUAL_SQ  = DEF_VISUAL_SQ,
  parameter fix15_t PROTECT_SQ = DEF_PROTECT_SQ,
  parameter fix15_t VISUAL     = DEF_VISUAL,
  parameter fix15_t CENTERING  = DEF_CENTERING,
  parameter fix15_t AVOID      = DEF_AVOID,
  parameter fix15_t MATCHING   = DEF_MATCHING,
  parameter fix15_t TURN       = DEF_TURN,
  parameter fix15_t MAXSPEED   = DEF_MAXSPEED,
  parameter fix15_t MINSPEED   = DEF_MINSPEED,
  parameter fix15_t LEFT       = DEF_LEFT,
  parameter fix15_t RIGHT      = DEF_RIGHT,
  parameter fix15_t TOP        = DEF_TOP,
  parameter fix15_t BOTTOM     = DEF_BOTTOM
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic             busy,
  output logic             done,
  input  logic             ld_valid,
  input  logic [IDX_W-1:0] ld_idx,
  input  logic [31:0]      ld_x,
  input  logic [31:0]      ld_y,
  input  logic [31:0]      ld_vx,
  input  logic [31:0]      ld_vy,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_x,
  output logic [31:0]      rd_y,
  output logic [31:0]      rd_vx,
  output logic [31:0]      rd_vy
);

  state_e           state_q, state_d;
  fix15_t           x_q [NUM_BOIDS];
  fix15_t           y_q [NUM_BOIDS];
  fix15_t           vx_q [NUM_BOIDS];
  fix15_t           vy_q [NUM_BOIDS];
  logic [IDX_W-1:0] i_q, j_q, n_q;
  logic [1:0]       div_sel_q;
  logic             div_wait_q;
  fix15_t           cx_q, cy_q, cvx_q, cvy_q;
  fix15_t           close_x_q, close_y_q, sum_x_q, sum_y_q, sum_vx_q, sum_vy_q;
  fix15_t           avg_x_q, avg_y_q, avg_vx_q, avg_vy_q;
  fix15_t           spd_q, spd_tgt_q;

  fix15_t dx, dy, d2, spd, div_a, div_b, div_q, flock_vx, flock_vy;
  logic   in_vis, last_j, last_i, div_start, div_valid, need_sdiv;

  assign dx        = cx_q - x_q[j_q];
  assign dy        = cy_q - y_q[j_q];
  assign in_vis    = (j_q != i_q) && (fabs(dx) < VISUAL) && (fabs(dy) < VISUAL);
  assign d2        = fmul(dx, dx) + fmul(dy, dy);
  assign spd       = amax_bmin(cvx_q, cvy_q);
  assign need_sdiv = (spd > MAXSPEED) || ((spd > 0) && (spd < MINSPEED));
  assign last_j    = j_q == IDX_W'(NUM_BOIDS - 1);
  assign last_i    = i_q == IDX_W'(NUM_BOIDS - 1);
  assign flock_vx  = (n_q != '0) ? fmul(avg_x_q - cx_q, CENTERING) + fmul(avg_vx_q - cvx_q, MATCHING) : '0;
  assign flock_vy  = (n_q != '0) ? fmul(avg_y_q - cy_q, CENTERING) + fmul(avg_vy_q - cvy_q, MATCHING) : '0;
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = state_q == S_DONE;

  // The divider is shared: neighbour averages in DIV, speed ratio in SDIV.
  assign div_start = ((state_q == S_DIV && n_q != '0) || state_q == S_SDIV) && !div_wait_q;

  always_comb begin
    div_a = spd_tgt_q;
    div_b = spd_q;
    if (state_q == S_DIV) begin
      div_b = 32'({n_q, 15'd0});
      case (div_sel_q)
        2'd0:    div_a = sum_x_q;
        2'd1:    div_a = sum_y_q;
        2'd2:    div_a = sum_vx_q;
        default: div_a = sum_vy_q;
      endcase
    end
  end

  boid_fix15_div u_div (
    .clk_i      (clk),
    .rst_ni     (reset),
    .start_i    (div_start),
    .dividend_i (div_a),
    .divisor_i  (div_b),
    .valid_o    (div_valid),
    .quot_o     (div_q)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (en) state_d = S_INIT;
      S_INIT:  state_d = S_SCAN;
      S_SCAN:  if (last_j) state_d = S_DIV;
      S_DIV:   if (n_q == '0 || (div_valid && div_sel_q == 2'd3)) state_d = S_APPLY;
      S_APPLY: state_d = S_EDGE;
      S_EDGE:  state_d = S_SPEED;
      S_SPEED: state_d = need_sdiv ? S_SDIV : S_POS;
      S_SDIV:  if (div_valid) state_d = S_POS;
      S_POS:   state_d = S_NEXT;
      S_NEXT:  state_d = last_i ? S_DONE : S_INIT;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_BOIDS; k++) begin
        x_q[k]  <= '0;
        y_q[k]  <= '0;
        vx_q[k] <= '0;
        vy_q[k] <= '0;
      end
      {i_q, j_q, n_q, div_sel_q, div_wait_q}                      <= '0;
      {cx_q, cy_q, cvx_q, cvy_q}                                  <= '0;
      {close_x_q, close_y_q, sum_x_q, sum_y_q, sum_vx_q, sum_vy_q} <= '0;
      {avg_x_q, avg_y_q, avg_vx_q, avg_vy_q, spd_q, spd_tgt_q}     <= '0;
    end else begin
      if (ld_valid && !busy) begin
        x_q[ld_idx]  <= ld_x;
        y_q[ld_idx]  <= ld_y;
        vx_q[ld_idx] <= ld_vx;
        vy_q[ld_idx] <= ld_vy;
      end
      case (state_q)
        S_IDLE: if (en) i_q <= '0;
        S_INIT: begin
          cx_q  <= x_q[i_q];
          cy_q  <= y_q[i_q];
          cvx_q <= vx_q[i_q];
          cvy_q <= vy_q[i_q];
          {close_x_q, close_y_q, sum_x_q, sum_y_q, sum_vx_q, sum_vy_q} <= '0;
          {j_q, n_q, div_sel_q, div_wait_q} <= '0;
        end
        S_SCAN: begin
          if (in_vis) begin
            if (d2 < PROTECT_SQ) begin
              close_x_q <= close_x_q + dx;
              close_y_q <= close_y_q + dy;
            end else if (d2 < VISUAL_SQ) begin
              sum_x_q  <= sum_x_q + x_q[j_q];
              sum_y_q  <= sum_y_q + y_q[j_q];
              sum_vx_q <= sum_vx_q + vx_q[j_q];
              sum_vy_q <= sum_vy_q + vy_q[j_q];
              n_q      <= n_q + 1'b1;
            end
          end
          j_q <= j_q + 1'b1;
        end
        S_DIV: begin
          if (div_start) div_wait_q <= 1'b1;
          if (div_valid) begin
            case (div_sel_q)
              2'd0:    avg_x_q  <= div_q;
              2'd1:    avg_y_q  <= div_q;
              2'd2:    avg_vx_q <= div_q;
              default: avg_vy_q <= div_q;
            endcase
            div_sel_q  <= div_sel_q + 2'd1;
            div_wait_q <= 1'b0;
          end
        end
        S_APPLY: begin
          cvx_q <= cvx_q + flock_vx + fmul(close_x_q, AVOID);
          cvy_q <= cvy_q + flock_vy + fmul(close_y_q, AVOID);
        end
        S_EDGE: begin
          cvx_q <= cvx_q + ((cx_q < LEFT) ? TURN : '0) - ((cx_q > RIGHT)  ? TURN : '0);
          cvy_q <= cvy_q + ((cy_q < TOP)  ? TURN : '0) - ((cy_q > BOTTOM) ? TURN : '0);
        end
        S_SPEED: begin
          spd_q     <= spd;
          spd_tgt_q <= (spd > MAXSPEED) ? MAXSPEED : MINSPEED;
        end
        S_SDIV: begin
          if (div_start) div_wait_q <= 1'b1;
          if (div_valid) begin
            cvx_q      <= fmul(cvx_q, div_q);
            cvy_q      <= fmul(cvy_q, div_q);
            div_wait_q <= 1'b0;
          end
        end
        S_POS: begin
          x_q[i_q]  <= cx_q + cvx_q;
          y_q[i_q]  <= cy_q + cvy_q;
          vx_q[i_q] <= cvx_q;
          vy_q[i_q] <= cvy_q;
        end
        S_NEXT: if (!last_i) i_q <= i_q + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_x  <= '0;
      rd_y  <= '0;
      rd_vx <= '0;
      rd_vy <= '0;
    end else begin
      rd_x  <= x_q[rd_idx];
      rd_y  <= y_q[rd_idx];
      rd_vx <= vx_q[rd_idx];
      rd_vy <= vy_q[rd_idx];
    end
  end

endmodule

// File: tb/tb_boid_flock_engine.sv
// Directed bench for boid_flock_engine: loads boid sets, runs frames and checks
// read-back state against hand-computed fix15 values through a scoreboard queue.
module tb_boid_flock_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        busy, done;
  logic        ld_valid = 1'b0;
  logic [2:0]  ld_idx = '0;
  logic [31:0] ld_x = '0, ld_y = '0, ld_vx = '0, ld_vy = '0;
  logic [2:0]  rd_idx = '0;
  logic [31:0] rd_x, rd_y, rd_vx, rd_vy;

  localparam logic [31:0] V4 = 32'h0002_0000;

  logic [127:0] exp_q[$];
  string        name_q[$];
  int           pass_cnt = 0;
  int           total_cnt = 0;
  int           done_cnt = 0;
  logic         rd_req = 1'b0;
  logic         rd_pipe;
  logic [127:0] mon_exp;
  string        mon_name;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  boid_flock_engine dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .busy     (busy),
    .done     (done),
    .ld_valid (ld_valid),
    .ld_idx   (ld_idx),
    .ld_x     (ld_x),
    .ld_y     (ld_y),
    .ld_vx    (ld_vx),
    .ld_vy    (ld_vy),
    .rd_idx   (rd_idx),
    .rd_x     (rd_x),
    .rd_y     (rd_y),
    .rd_vx    (rd_vx),
    .rd_vy    (rd_vy)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) rd_pipe <= 1'b0;
    else        rd_pipe <= rd_req;
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (rd_pipe) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL rd_unexpected: got %h expected no read", {rd_x, rd_y, rd_vx, rd_vy});
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        check(mon_name, {rd_x, rd_y, rd_vx, rd_vy}, mon_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] px(input int p);
    return 32'(p) << 15;
  endfunction

  task automatic load(input logic [2:0] idx, input logic [31:0] x, y, vx, vy);
    @(negedge clk);
    ld_valid = 1'b1; ld_idx = idx; ld_x = x; ld_y = y; ld_vx = vx; ld_vy = vy;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  // Boids 1..7 spread at least ~90 px apart and from (320,240)/(324,240).
  task automatic load_layout();
    load(3'd1, px(150), px(150), V4, '0);
    load(3'd2, px(250), px(150), V4, '0);
    load(3'd3, px(450), px(150), V4, '0);
    load(3'd4, px(150), px(330), V4, '0);
    load(3'd5, px(250), px(330), V4, '0);
    load(3'd6, px(450), px(330), V4, '0);
    load(3'd7, px(450), px(240), V4, '0);
  endtask

  task automatic read(input logic [2:0] idx, input logic [127:0] exp, input string nm);
    @(negedge clk);
    rd_idx = idx;
    rd_req = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic start_frame(input bit with_ld, input logic [31:0] x, y, vx, vy);
    @(negedge clk);
    done_cnt = 0;
    en = 1'b1;
    if (with_ld) begin
      ld_valid = 1'b1; ld_idx = 3'd0; ld_x = x; ld_y = y; ld_vx = vx; ld_vy = vy;
    end
    @(negedge clk);
    en = 1'b0;
    ld_valid = 1'b0;
  endtask

  task automatic wait_frame(input string nm, input bit disturb);
    int k;
    k = 0;
    while (done_cnt == 0 && k < 5000) begin
      @(negedge clk);
      k++;
      if (k == 5) check({nm, "_busy"}, 128'(busy), 128'd1);
      if (disturb && (k == 20 || k == 60)) begin
        en = 1'b1; ld_valid = 1'b1; ld_idx = 3'd0;
        ld_x = 32'h1234_5678; ld_y = 32'h0765_4321; ld_vx = 32'h0001_0000; ld_vy = 32'h0001_0000;
      end else begin
        en = 1'b0; ld_valid = 1'b0;
      end
    end
    en = 1'b0;
    ld_valid = 1'b0;
    check({nm, "_done_seen"}, 128'(done_cnt != 0), 128'd1);
    repeat (20) @(negedge clk);
    check({nm, "_one_done"}, 128'(done_cnt), 128'd1);
    check({nm, "_idle"}, 128'(busy), 128'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("por_busy", 128'(busy), 128'd0);
    check("por_done", 128'(done), 128'd0);
    check("por_rd", {rd_x, rd_y, rd_vx, rd_vy}, 128'd0);
    reset = 1'b1;

    // Reset in the middle of a frame aborts it and clears every boid.
    load_layout();
    load(3'd0, px(320), px(240), V4, '0);
    start_frame(1'b0, '0, '0, '0, '0);
    repeat (30) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_done", 128'(done), 128'd0);
    for (int k = 0; k < 8; k++) read(3'(k), 128'd0, "midrst_clear");

    // All boids at origin: edge turn both axes, then min-speed rescale.
    start_frame(1'b0, '0, '0, '0, '0);
    wait_frame("zero", 1'b0);
    read(3'd0, {32'h0001_0003, 32'h0001_0003, 32'h0001_0003, 32'h0001_0003}, "zero_b0");

    // Isolated boid, no rule active.
    load_layout();
    load(3'd0, px(320), px(240), V4, '0);
    start_frame(1'b0, '0, '0, '0, '0);
    wait_frame("iso", 1'b0);
    read(3'd0, {32'h00A2_0000, 32'h0078_0000, 32'h0002_0000, 32'h0}, "iso_b0");
    read(3'd7, {32'h00E3_0000, 32'h0078_0000, 32'h0002_0000, 32'h0}, "iso_b7");

    // Left-margin turn.
    load_layout();
    load(3'd0, px(50), px(240), V4, '0);
    start_frame(1'b0, '0, '0, '0, '0);
    wait_frame("edge", 1'b0);
    read(3'd0, {32'h001B_1999, 32'h0078_0000, 32'h0002_1999, 32'h0}, "edge_b0");
    read(3'd1, {32'h004D_0000, 32'h004B_0000, 32'h0002_0000, 32'h0}, "edge_b1");

    // Max-speed clamp; boid 0 loaded in the same cycle as en.
    load_layout();
    start_frame(1'b1, px(320), px(240), 32'h0004_0000, '0);
    wait_frame("fast", 1'b0);
    read(3'd0, {32'h00A3_0000, 32'h0078_0000, 32'h0003_0000, 32'h0}, "fast_b0");

    // Two boids in protected range: separation only.
    load_layout();
    load(3'd1, px(324), px(240), V4, '0);
    load(3'd0, px(320), px(240), V4, '0);
    start_frame(1'b0, '0, '0, '0, '0);
    wait_frame("sep", 1'b0);
    read(3'd0, {32'h00A1_E668, 32'h0078_0000, 32'h0001_E668, 32'h0}, "sep_b0");
    read(3'd1, {32'h00A4_0147, 32'h0078_0000, 32'h0002_0147, 32'h0}, "sep_b1");

    // en and ld_valid pulsed while busy must have no effect.
    load_layout();
    load(3'd0, px(320), px(240), V4, '0);
    start_frame(1'b0, '0, '0, '0, '0);
    wait_frame("disturb", 1'b1);
    read(3'd0, {32'h00A2_0000, 32'h0078_0000, 32'h0002_0000, 32'h0}, "disturb_b0");
    read(3'd7, {32'h00E3_0000, 32'h0078_0000, 32'h0002_0000, 32'h0}, "disturb_b7");

    // ---------------- report ----------------
    repeat (5) @(negedge clk);
    check("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
